// File: rtl/vx_dp_ram_fifo_ctrl.sv
// Valid/ready queue on top of an external dual-port RAM with a registered read port.
// A 2-entry flop buffer absorbs the 1-cycle read latency for full dequeue throughput.
module vx_dp_ram_fifo_ctrl #(
  parameter int DATAW = 32,
  parameter int SIZE  = 16,
  parameter int ADDRW = $clog2(SIZE),
  parameter int CNTW  = $clog2(SIZE + 3)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [DATAW-1:0] enq_data,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [DATAW-1:0] deq_data,
  output logic [CNTW-1:0]  count,
  output logic             ram_wren,
  output logic [ADDRW-1:0] ram_waddr,
  output logic [DATAW-1:0] ram_wdata,
  output logic [ADDRW-1:0] ram_raddr,
  input  logic [DATAW-1:0] ram_rdata
);

  localparam int RCW = ADDRW + 1;

  logic [ADDRW-1:0] wr_ptr;
  logic [ADDRW-1:0] rd_ptr;
  logic [RCW-1:0]   ram_count;
  logic             pending;
  logic [1:0]       out_count;
  logic [DATAW-1:0] head;
  logic [DATAW-1:0] second;

  logic       enq_fire;
  logic       deq_fire;
  logic       issue;
  logic [1:0] occ_after_pop;
  logic [1:0] cap_idx;

  always_comb begin
    enq_ready     = reset_n & (ram_count != RCW'(SIZE)) & ~flush;
    enq_fire      = enq_valid & enq_ready;
    deq_valid     = (out_count != 2'd0);
    deq_fire      = deq_valid & deq_ready;
    occ_after_pop = out_count + 2'(pending) - 2'(deq_fire);
    issue         = (ram_count != '0) & (occ_after_pop < 2'd2) & ~flush;
    // Captured word goes to the slot left free after any same-cycle pop.
    cap_idx       = out_count - 2'(deq_fire);
    deq_data      = head;
    count         = CNTW'(ram_count) + CNTW'(pending) + CNTW'(out_count);
    ram_wren      = enq_fire;
    ram_waddr     = wr_ptr;
    ram_wdata     = enq_data;
    ram_raddr     = rd_ptr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
      pending   <= 1'b0;
      out_count <= '0;
      head      <= '0;
      second    <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
      pending   <= 1'b0;
      out_count <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
      if (issue)    rd_ptr <= rd_ptr + 1'b1;
      case ({enq_fire, issue})
        2'b10:   ram_count <= ram_count + 1'b1;
        2'b01:   ram_count <= ram_count - 1'b1;
        default: ram_count <= ram_count;
      endcase
      pending   <= issue;
      out_count <= out_count + 2'(pending) - 2'(deq_fire);
      if (deq_fire) head <= second;
      if (pending) begin
        if (cap_idx == 2'd0) head <= ram_rdata;
        else                 second <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vx_dp_ram_fifo_ctrl.sv
// Scoreboard bench for vx_dp_ram_fifo_ctrl with a behavioural registered-read RAM.
module tb_vx_dp_ram_fifo_ctrl;

  localparam int DATAW = 32;
  localparam int SIZE  = 16;
  localparam int ADDRW = 4;
  localparam int CNTW  = 5;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush = 1'b0;
  logic             enq_valid = 1'b0;
  logic             enq_ready;
  logic [DATAW-1:0] enq_data = '0;
  logic             deq_valid;
  logic             deq_ready = 1'b0;
  logic [DATAW-1:0] deq_data;
  logic [CNTW-1:0]  count;
  logic             ram_wren;
  logic [ADDRW-1:0] ram_waddr;
  logic [DATAW-1:0] ram_wdata;
  logic [ADDRW-1:0] ram_raddr;
  logic [DATAW-1:0] ram_rdata = '0;

  logic [DATAW-1:0] mem [SIZE];
  logic [DATAW-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int sent;

  vx_dp_ram_fifo_ctrl #(.DATAW(DATAW), .SIZE(SIZE)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
    .count(count), .ram_wren(ram_wren), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  function automatic void check(input string nm, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, actual, expected);
    end
  endfunction

  // Monitor: expected words enter on accepted enqueue, leave on dequeue.
  always @(negedge clk) begin
    if (!reset_n || flush) begin
      exp_q.delete();
    end else begin
      if (deq_valid && deq_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL deq_unexpected actual=%0h required=none", deq_data);
        end else begin
          check("deq_data", deq_data, exp_q.pop_front());
        end
      end
      if (enq_valid && enq_ready) exp_q.push_back(enq_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call in the cycle after the enqueue cycle with deq_ready=1.
  task automatic probe3(input string nm, input logic [DATAW-1:0] val);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check({nm, "_valid"}, deq_valid, (k == 3) ? 1 : 0);
      if (k == 3) check({nm, "_data"}, deq_data, val);
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < SIZE; i++) mem[i] = '0;

    // Reset state
    @(negedge clk);
    check("rst_deq_valid", deq_valid, 0);
    check("rst_count", count, 0);
    check("rst_enq_ready", enq_ready, 0);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_enq_ready", enq_ready, 1);
    step();

    // Single entry latency and count profile
    enq_valid = 1'b1; enq_data = 32'hA5; deq_ready = 1'b1;
    @(negedge clk);
    step();
    enq_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("single_count", count, (k == 4) ? 0 : 1);
      check("single_valid", deq_valid, (k == 3) ? 1 : 0);
      if (k == 3) check("single_data", deq_data, 32'hA5);
      step();
    end

    // Fill to capacity with the consumer stalled, then drain
    deq_ready = 1'b0; enq_valid = 1'b1; sent = 0;
    for (int c = 0; c < 30; c++) begin
      enq_data = DATAW'(sent);
      @(negedge clk);
      if (enq_ready) sent++;
      step();
    end
    enq_valid = 1'b0;
    check("fill_accepts", sent, 18);
    @(negedge clk);
    check("fill_count", count, 18);
    check("fill_enq_ready", enq_ready, 0);
    check("fill_head_valid", deq_valid, 1);
    check("fill_head", deq_data, 0);
    step();
    deq_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      check("drain_valid", deq_valid, 1);
      step();
    end
    @(negedge clk);
    check("drain_count", count, 0);
    check("drain_empty", deq_valid, 0);
    step();

    // Streaming at full rate
    enq_valid = 1'b1; sent = 0;
    for (int c = 0; c < 100; c++) begin
      enq_data = DATAW'(1000 + sent);
      @(negedge clk);
      if (enq_ready) sent++;
      if (c >= 3) begin
        check("stream_valid", deq_valid, 1);
        check("stream_count", count, 3);
      end else begin
        check("stream_prime_count", count, c);
      end
      step();
    end
    enq_valid = 1'b0;
    for (int c = 0; c < 10 && count != 0; c++) step();
    check("stream_drained", count, 0);

    // Random backpressure across pointer wrap
    sent = 0;
    for (int c = 0; c < 400 && (sent < 40 || count != 0); c++) begin
      deq_ready = 1'($urandom_range(0, 1));
      enq_valid = (sent < 40);
      enq_data  = DATAW'(2000 + sent);
      @(negedge clk);
      check("bp_count_over_max", (count > 18) ? 1 : 0, 0);
      if (enq_valid && enq_ready) sent++;
      step();
    end
    enq_valid = 1'b0; deq_ready = 1'b0;
    check("bp_sent", sent, 40);
    check("bp_drained", count, 0);
    check("bp_queue_empty", exp_q.size(), 0);

    // Flush with a read in flight and the output buffer occupied
    for (int i = 0; i < 3; i++) begin
      enq_valid = 1'b1; enq_data = DATAW'(300 + i);
      @(negedge clk);
      step();
    end
    enq_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("fl_pre_count", count, 3);
    check("fl_pre_valid", deq_valid, 1);
    step();
    flush = 1'b0;
    @(negedge clk);
    check("fl_post_valid", deq_valid, 0);
    check("fl_post_count", count, 0);
    step();
    deq_ready = 1'b1; enq_valid = 1'b1; enq_data = 32'h77;
    @(negedge clk);
    step();
    enq_valid = 1'b0;
    probe3("fl_new", 32'h77);

    // Reset in the middle of a stream
    enq_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      enq_data = DATAW'(500 + i);
      @(negedge clk);
      step();
    end
    reset_n = 1'b0;
    @(negedge clk);
    check("rs_deq_valid", deq_valid, 0);
    check("rs_count", count, 0);
    check("rs_enq_ready", enq_ready, 0);
    step();
    reset_n = 1'b1; enq_data = 32'h5C;
    @(negedge clk);
    check("rs_rel_enq_ready", enq_ready, 1);
    step();
    enq_valid = 1'b0;
    probe3("rs_new", 32'h5C);

    @(negedge clk);
    check("final_count", count, 0);
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
